// File: rtl/mode_cfg_pkg.sv
// Shared types and constants for the mode-dependent config write sequencer.
package mode_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] USER_DATA_TAG = 8'hA5;
  localparam logic [7:0] DEF_DATA_TAG  = 8'h00;

  // Upper byte tags the mode, lower byte carries the write index.
  function automatic logic [15:0] data_pattern(input logic mode, input logic [7:0] idx);
    return {(mode ? USER_DATA_TAG : DEF_DATA_TAG), idx};
  endfunction

endpackage

// File: rtl/mode_cfg_sequencer_hs_timeout_cnt.sv
// Saturating wait counter for a pending handshake; expired is high once run has been
// asserted TIMEOUT-1 edges since the last clear, so the caller aborts on the TIMEOUT-th edge.
module hs_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mode_cfg_sequencer.sv
// Latches user_mode on start and issues NUM_WR back-to-back config writes over valid/ready,
// with mode-selected address base and data tag; a stalled write aborts after TIMEOUT cycles.
module mode_cfg_sequencer
  import mode_cfg_pkg::*;
#(
  parameter int                NUM_WR       = 4,
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] USER_BASE    = 'h40,
  parameter logic [ADDR_W-1:0] DEFAULT_BASE = 'h00,
  parameter int                TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_mode,
  input  logic              start,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mode_latched
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WR - 1);

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic       start_acc, accept, last, expired, timeout, tmo_clear, tmo_run;
  logic [7:0] idx_nxt;

  assign start_acc = start && (state_q != WRITE);
  assign accept    = (state_q == WRITE) && valid_q && wr_ready;
  assign last      = (idx_q == LAST_IDX);
  // A ready arriving on the expiry edge takes priority over the abort.
  assign timeout   = (state_q == WRITE) && !wr_ready && expired;
  assign tmo_clear = start_acc || (accept && !last);
  assign tmo_run   = (state_q == WRITE) && !wr_ready;
  assign idx_nxt   = idx_q + 8'd1;

  hs_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .run     (tmo_run),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if ((accept && last) || timeout) state_d = DONE;
      DONE:    if (start) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    if (start_acc) begin
      idx_d  = 8'd0;
      mode_d = user_mode;
      addr_d = user_mode ? USER_BASE : DEFAULT_BASE;
      data_d = DATA_W'(data_pattern(user_mode, 8'd0));
      err_d  = 1'b0;
    end else if (accept && !last) begin
      idx_d  = idx_nxt;
      addr_d = (mode_q ? USER_BASE : DEFAULT_BASE) + ADDR_W'(idx_nxt);
      data_d = DATA_W'(data_pattern(mode_q, idx_nxt));
    end else if (timeout) begin
      err_d  = 1'b1;
    end
    valid_d = (state_d == WRITE);
    busy_d  = (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_valid     = valid_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mode_latched = mode_q;

endmodule
